reg_file_seq: RTL and testbench

- Parametrised successor to the fixed 16x8 processor register file.
- Configurable width and depth; two asynchronous read ports and one synchronous write port.
- Built-in sequencer replaces bench-side backdoor initialisation and display loops:
  - Init: fills every register with a value.
  - Dump: streams all registers out, one per cycle.
- Sits inside TopLevel in place of the old register file; the Start/Ack style handshake is reused for sequencer commands.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_seq_ctrl.sv | 84 ++++++++
 rtl/reg_file_seq.sv | 88 ++++++++
 tb/tb_reg_file_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and default sizing for the sequenced register file.
package rf_pkg;

  localparam int unsigned RF_DEF_WIDTH = 8;
  localparam int unsigned RF_DEF_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    DUMP,
    DONE
  } rf_state_e;

endpackage

// File: rtl/rf_seq_ctrl.sv
// Init/dump sequencer: state machine, register index counter and handshake strobes.
module rf_seq_ctrl
  import rf_pkg::*;
#(
  parameter  int unsigned DEPTH  = RF_DEF_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_init_req,
  input  logic              i_dump_req,
  output logic              o_seq_we,
  output logic [ADDR_W-1:0] o_seq_addr,
  output logic              o_ext_we_ok,
  output logic              o_dump_fire,
  output logic              o_busy,
  output logic              o_ack,
  output logic              o_dump_valid,
  output logic [ADDR_W-1:0] o_dump_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rf_state_e         r_state;
  rf_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic              r_ack;
  logic              r_dump_valid;
  logic [ADDR_W-1:0] r_dump_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_ack        <= 1'b0;
      r_dump_valid <= 1'b0;
      r_dump_addr  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_ack        <= (r_state == DONE);
      r_dump_valid <= (r_state == DUMP);
      if (r_state == DUMP) begin
        r_dump_addr <= r_idx;
      end
    end
  end

  // Terminal index is decoded explicitly; the counter itself just wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      IDLE: begin
        if (i_init_req) begin
          w_state_nxt = INIT;
          w_idx_nxt   = '0;
        end else if (i_dump_req) begin
          w_state_nxt = DUMP;
          w_idx_nxt   = '0;
        end
      end
      INIT, DUMP: begin
        w_idx_nxt = r_idx + ADDR_W'(1);
        if (r_idx == LAST_IDX) begin
          w_state_nxt = DONE;
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_seq_we     = (r_state == INIT);
  assign o_seq_addr   = r_idx;
  assign o_ext_we_ok  = (r_state == IDLE) || (r_state == DUMP);
  assign o_dump_fire  = (r_state == DUMP);
  assign o_busy       = (r_state != IDLE);
  assign o_ack        = r_ack;
  assign o_dump_valid = r_dump_valid;
  assign o_dump_addr  = r_dump_addr;

endmodule

// File: rtl/reg_file_seq.sv
// Parametrised register file, 2 async read ports, 1 sync write port, init/dump sequencer.
// Optional write-first read forwarding: define RF_WRITE_BYPASS_EN.
module reg_file_seq
  import rf_pkg::*;
#(
  parameter  int unsigned WIDTH  = RF_DEF_WIDTH,
  parameter  int unsigned DEPTH  = RF_DEF_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [WIDTH-1:0]  WrData,
  input  logic [ADDR_W-1:0] RdAddrA,
  output logic [WIDTH-1:0]  RdDataA,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [WIDTH-1:0]  RdDataB,
  input  logic              InitReq,
  input  logic [WIDTH-1:0]  InitValue,
  input  logic              DumpReq,
  output logic              Busy,
  output logic              DumpValid,
  output logic [ADDR_W-1:0] DumpAddr,
  output logic [WIDTH-1:0]  DumpData,
  output logic              Ack
);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_dump_data;
  logic              w_seq_we;
  logic [ADDR_W-1:0] w_seq_addr;
  logic              w_ext_we_ok;
  logic              w_ext_we;
  logic              w_dump_fire;

  rf_seq_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .i_clk        (Clk),
    .i_rst        (Reset),
    .i_init_req   (InitReq),
    .i_dump_req   (DumpReq),
    .o_seq_we     (w_seq_we),
    .o_seq_addr   (w_seq_addr),
    .o_ext_we_ok  (w_ext_we_ok),
    .o_dump_fire  (w_dump_fire),
    .o_busy       (Busy),
    .o_ack        (Ack),
    .o_dump_valid (DumpValid),
    .o_dump_addr  (DumpAddr)
  );

  assign w_ext_we = WrEn && w_ext_we_ok;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_seq_we) begin
      r_mem[w_seq_addr] <= InitValue;
    end else if (w_ext_we) begin
      r_mem[WrAddr] <= WrData;
    end
  end

  // Dump beat samples pre-edge contents, so a same-cycle write is not seen.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_dump_data <= '0;
    end else if (w_dump_fire) begin
      r_dump_data <= r_mem[w_seq_addr];
    end
  end

  assign DumpData = r_dump_data;

  always_comb begin
    RdDataA = r_mem[RdAddrA];
    RdDataB = r_mem[RdAddrB];
`ifdef RF_WRITE_BYPASS_EN
    if (w_ext_we && (WrAddr == RdAddrA)) RdDataA = WrData;
    if (w_ext_we && (WrAddr == RdAddrB)) RdDataB = WrData;
`endif
  end

endmodule

// File: tb/tb_reg_file_seq.sv
// Self-checking bench for reg_file_seq (WIDTH=8, DEPTH=16) against an array model.
module tb_reg_file_seq;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          Clk = 1'b0;
  logic          Reset, WrEn, InitReq, DumpReq;
  logic [AW-1:0] WrAddr, RdAddrA, RdAddrB;
  logic [W-1:0]  WrData, InitValue;
  logic [W-1:0]  RdDataA, RdDataB, DumpData;
  logic          Busy, DumpValid, Ack;
  logic [AW-1:0] DumpAddr;

  logic [W-1:0] model [D];
  int checks = 0;
  int errors = 0;

`ifdef RF_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_file_seq #(.WIDTH(W), .DEPTH(D)) dut (
    .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdAddrA(RdAddrA), .RdDataA(RdDataA), .RdAddrB(RdAddrB), .RdDataB(RdDataB),
    .InitReq(InitReq), .InitValue(InitValue), .DumpReq(DumpReq), .Busy(Busy),
    .DumpValid(DumpValid), .DumpAddr(DumpAddr), .DumpData(DumpData), .Ack(Ack)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < D; i++) begin
      RdAddrA = AW'(i);
      RdAddrB = AW'(D - 1 - i);
      #1;
      checks++; if (RdDataA !== model[i]) begin errors++; $display("FAIL %s rdA[%0d] got %h exp %h", tag, i, RdDataA, model[i]); end
      checks++; if (RdDataB !== model[D-1-i]) begin errors++; $display("FAIL %s rdB[%0d] got %h exp %h", tag, D-1-i, RdDataB, model[D-1-i]); end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    foreach (model[i]) model[i] = '0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
    checks++; if (Ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", Ack); end
    checks++; if (DumpValid !== 1'b0) begin errors++; $display("FAIL reset_dvalid got %b exp 0", DumpValid); end
    checks++; if (DumpAddr !== '0) begin errors++; $display("FAIL reset_daddr got %h exp 0", DumpAddr); end
    checks++; if (DumpData !== '0) begin errors++; $display("FAIL reset_ddata got %h exp 0", DumpData); end
    check_all_regs("reset");
  endtask

  // rand_vals: new InitValue each cycle; with_dump: DumpReq held high during INIT;
  // also drives ignored external writes while the sequencer owns the port.
  task automatic test_init(input bit rand_vals, input bit with_dump, input string tag);
    int acks = 0;
    InitReq   = 1'b1;
    DumpReq   = with_dump;
    InitValue = rand_vals ? W'($urandom) : 8'h01;
    tick();
    InitReq = 1'b0;
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL %s busy_start got %b exp 1", tag, Busy); end
    for (int n = 1; n <= 20; n++) begin
      if (n <= D) begin
        if (rand_vals) InitValue = W'($urandom);
        model[n-1] = InitValue;
        WrEn   = rand_vals && (n < D);
        WrAddr = AW'($urandom);
        WrData = W'($urandom);
      end else begin
        WrEn = 1'b0;
      end
      if (n >= 15) DumpReq = 1'b0;
      tick();
      if (Ack === 1'b1) acks++;
      checks++; if (Ack !== (n == D + 1)) begin errors++; $display("FAIL %s ack_n%0d got %b exp %b", tag, n, Ack, (n == D + 1)); end
      checks++; if (DumpValid !== 1'b0) begin errors++; $display("FAIL %s no_dump_n%0d got %b exp 0", tag, n, DumpValid); end
    end
    WrEn = 1'b0;
    checks++; if (acks != 1) begin errors++; $display("FAIL %s ack_count got %0d exp 1", tag, acks); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL %s busy_end got %b exp 0", tag, Busy); end
    check_all_regs(tag);
  endtask

  task automatic test_dump();
    logic [W-1:0] exp_d;
    int k;
    WrEn = 1'b1; WrAddr = 4'd3;  WrData = 8'hA5; tick(); model[3]  = 8'hA5;
    WrEn = 1'b1; WrAddr = 4'd15; WrData = 8'h3C; tick(); model[15] = 8'h3C;
    WrEn = 1'b0;
    DumpReq = 1'b1;
    tick();
    DumpReq = 1'b0;
    for (int n = 1; n <= D + 2; n++) begin
      k = n - 1;
      exp_d = (n <= D) ? model[k] : '0;
      WrEn = (n <= D) && (k % 2 == 0);
      WrAddr = AW'(k);
      WrData = W'($urandom);
      tick();
      if (WrEn) model[k] = WrData;
      WrEn = 1'b0;
      if (n <= D) begin
        checks++; if (DumpValid !== 1'b1) begin errors++; $display("FAIL dump_valid_b%0d got %b exp 1", k, DumpValid); end
        checks++; if (DumpAddr !== AW'(k)) begin errors++; $display("FAIL dump_addr_b%0d got %0d exp %0d", k, DumpAddr, k); end
        checks++; if (DumpData !== exp_d) begin errors++; $display("FAIL dump_data_b%0d got %h exp %h", k, DumpData, exp_d); end
        checks++; if (Ack !== 1'b0) begin errors++; $display("FAIL dump_ack_early_b%0d got %b exp 0", k, Ack); end
      end else begin
        checks++; if (DumpValid !== 1'b0) begin errors++; $display("FAIL dump_valid_after_n%0d got %b exp 0", n, DumpValid); end
        checks++; if (Ack !== (n == D + 1)) begin errors++; $display("FAIL dump_ack_n%0d got %b exp %b", n, Ack, (n == D + 1)); end
      end
    end
    check_all_regs("dump_post");
  endtask

  task automatic test_reset_mid_init();
    InitReq = 1'b1; InitValue = 8'hFF;
    tick();
    InitReq = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    foreach (model[i]) model[i] = '0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", Busy); end
    for (int n = 0; n < 20; n++) begin
      tick();
      checks++; if (Ack !== 1'b0) begin errors++; $display("FAIL midrst_ack_n%0d got %b exp 0", n, Ack); end
    end
    check_all_regs("midrst");
  endtask

  task automatic test_bypass();
    logic [W-1:0] old7;
    old7 = model[7];
    WrEn = 1'b1; WrAddr = 4'd7; WrData = 8'h5A; RdAddrA = 4'd7; RdAddrB = 4'd6;
    #1;
    checks++; if (RdDataA !== (BYPASS ? 8'h5A : old7)) begin errors++; $display("FAIL bypass_same got %h exp %h", RdDataA, BYPASS ? 8'h5A : old7); end
    checks++; if (RdDataB !== model[6]) begin errors++; $display("FAIL bypass_other got %h exp %h", RdDataB, model[6]); end
    tick();
    model[7] = 8'h5A;
    WrEn = 1'b0;
    checks++; if (RdDataA !== 8'h5A) begin errors++; $display("FAIL bypass_next got %h exp 5a", RdDataA); end
  endtask

  task automatic test_random_rw();
    logic [W-1:0] ea, eb;
    for (int n = 0; n < 200; n++) begin
      WrEn = 1'($urandom); WrAddr = AW'($urandom); WrData = W'($urandom);
      RdAddrA = AW'($urandom); RdAddrB = (n % 4 == 0) ? WrAddr : AW'($urandom);
      #1;
      ea = (BYPASS && WrEn && WrAddr == RdAddrA) ? WrData : model[RdAddrA];
      eb = (BYPASS && WrEn && WrAddr == RdAddrB) ? WrData : model[RdAddrB];
      checks++; if (RdDataA !== ea) begin errors++; $display("FAIL rand_rdA n%0d got %h exp %h", n, RdDataA, ea); end
      checks++; if (RdDataB !== eb) begin errors++; $display("FAIL rand_rdB n%0d got %h exp %h", n, RdDataB, eb); end
      tick();
      if (WrEn) model[WrAddr] = WrData;
    end
    WrEn = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rand_busy got %b exp 0", Busy); end
    check_all_regs("rand_post");
  endtask

  initial begin
    Reset = 1'b1; WrEn = 1'b0; WrAddr = '0; WrData = '0;
    RdAddrA = '0; RdAddrB = '0; InitReq = 1'b0; InitValue = '0; DumpReq = 1'b0;
    test_reset();
    test_init(1'b0, 1'b0, "init01");
    test_dump();
    test_init(1'b1, 1'b1, "init_prio");
    test_reset_mid_init();
    test_bypass();
    test_random_rw();
    test_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
